// File: rtl/piso_pkg.sv
// piso_pkg: shared word width, FSM encodings and parity helper for the PISO transmitter
package piso_pkg;
  localparam int WORD_W = 8;
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } state_e;
  function automatic logic even_par(input logic [WORD_W-1:0] d);
    return ^d;
  endfunction
endpackage

// File: rtl/piso_shreg.sv
// piso_shreg: loadable left-shift register exposing its MSB
module piso_shreg import piso_pkg::*; (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              shift_i,
  input  logic [WORD_W-1:0] d_i,
  output logic              msb_o
);
  logic [WORD_W-1:0] q_q;
  always_ff @(posedge clk)
    if (rst) q_q <= '0;
    else if (load_i) q_q <= d_i;
    else if (shift_i) q_q <= {q_q[WORD_W-2:0], 1'b0};
  assign msb_o = q_q[WORD_W-1];
endmodule

// File: rtl/piso_tx.sv
// piso_tx: byte-wide valid/ready in, MSB-first serial out with trailing even parity bit
module piso_tx import piso_pkg::*; (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [WORD_W-1:0] DATA_IN,
  input  logic              VALID_IN,
  output logic              READY_OUT,
  output logic              SERIAL_OUT,
  output logic              SERIAL_VALID,
  output logic              FRAME_START
);
  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        par_q, par_d, ser_q, ser_d, sv_q, fs_q;
  logic        load, shift, nxt_msb, xfer;
  assign READY_OUT    = !RESET && (state_q == ST_IDLE || state_q == ST_PARITY);
  assign xfer         = VALID_IN && READY_OUT;
  assign SERIAL_OUT   = ser_q;
  assign SERIAL_VALID = sv_q;
  assign FRAME_START  = fs_q;
  // The MSB goes straight into the output flop at load, so the shifter holds the bits still to come
  piso_shreg u_shreg (
    .clk     (CLK),
    .rst     (RESET),
    .load_i  (load),
    .shift_i (shift),
    .d_i     ({DATA_IN[WORD_W-2:0], 1'b0}),
    .msb_o   (nxt_msb)
  );
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = cnt_q;
    par_d   = par_q;
    ser_d   = 1'b0;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      ST_IDLE, ST_PARITY: if (xfer) begin
        state_d = ST_SHIFT;
        load    = 1'b1;
        cnt_d   = 3'd0;
        par_d   = even_par(DATA_IN);
        ser_d   = DATA_IN[WORD_W-1];
      end
      ST_SHIFT: begin
        shift   = 1'b1;
        cnt_d   = cnt_q + 3'd1;
        state_d = (cnt_q == 3'd7) ? ST_PARITY : ST_SHIFT;
        ser_d   = (cnt_q == 3'd7) ? par_q : nxt_msb;
      end
      default: ;
    endcase
  end
  always_ff @(posedge CLK)
    if (RESET) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      par_q   <= 1'b0;
      ser_q   <= 1'b0;
      sv_q    <= 1'b0;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      par_q   <= par_d;
      ser_q   <= ser_d;
      sv_q    <= (state_d != ST_IDLE);
      fs_q    <= load;
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: vector table plus directed frame sequences for piso_tx
module tb_piso_tx;
  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic [7:0] DATA_IN = 8'h00;
  logic       VALID_IN = 1'b0;
  logic       READY_OUT, SERIAL_OUT, SERIAL_VALID, FRAME_START;
  int         n_cmp = 0;
  int         n_err = 0;
  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] d;
    logic       rdy;
    logic       ser;
    logic       sv;
    logic       fs;
  } vec_t;
  vec_t       tbl[14];
  logic [8:0] fr;
  piso_tx dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .DATA_IN      (DATA_IN),
    .VALID_IN     (VALID_IN),
    .READY_OUT    (READY_OUT),
    .SERIAL_OUT   (SERIAL_OUT),
    .SERIAL_VALID (SERIAL_VALID),
    .FRAME_START  (FRAME_START)
  );
  always #5 CLK = ~CLK;
  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
    end
  endtask
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask
  // Sends one word from IDLE and checks the full 9-bit frame; alt is driven on DATA_IN during shifting
  task automatic send_check(input logic [7:0] d, input logic [7:0] alt, output logic [8:0] f);
    logic [8:0] exp_f;
    int w;
    exp_f = {d, ^d};
    w = 0;
    VALID_IN = 1'b1;
    DATA_IN  = d;
    #1;
    while (!READY_OUT && w < 20) begin
      tick();
      w++;
    end
    chk("ready_wait", {31'd0, READY_OUT}, 32'd1);
    tick();
    VALID_IN = 1'b0;
    DATA_IN  = alt;
    for (int i = 0; i < 9; i++) begin
      f[8-i] = SERIAL_OUT;
      chk("ser_bit", {31'd0, SERIAL_OUT}, {31'd0, exp_f[8-i]});
      chk("ser_valid", {31'd0, SERIAL_VALID}, 32'd1);
      chk("frame_start", {31'd0, FRAME_START}, {31'd0, i == 0});
      chk("ready_busy", {31'd0, READY_OUT}, {31'd0, i == 8});
      tick();
    end
    chk("idle_after_frame", {30'd0, SERIAL_VALID, SERIAL_OUT}, 32'd0);
  endtask
  initial begin
    tbl[0]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 1'b1, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[10] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 14; i++) begin
      RESET    = tbl[i].rst;
      VALID_IN = tbl[i].vld;
      DATA_IN  = tbl[i].d;
      #1;
      chk($sformatf("tbl%0d_ready", i), {31'd0, READY_OUT}, {31'd0, tbl[i].rdy});
      tick();
      chk($sformatf("tbl%0d_ser", i), {31'd0, SERIAL_OUT}, {31'd0, tbl[i].ser});
      chk($sformatf("tbl%0d_sv", i), {31'd0, SERIAL_VALID}, {31'd0, tbl[i].sv});
      chk($sformatf("tbl%0d_fs", i), {31'd0, FRAME_START}, {31'd0, tbl[i].fs});
    end
    begin : back_to_back
      logic [17:0] exp_b;
      exp_b = {8'h01, 1'b1, 8'h80, 1'b1};
      VALID_IN = 1'b1;
      DATA_IN  = 8'h01;
      for (int i = 0; i < 18; i++) begin
        tick();
        if (i == 0) DATA_IN = 8'h80;
        if (i == 9) VALID_IN = 1'b0;
        chk("b2b_ser", {31'd0, SERIAL_OUT}, {31'd0, exp_b[17-i]});
        chk("b2b_sv", {31'd0, SERIAL_VALID}, 32'd1);
        chk("b2b_fs", {31'd0, FRAME_START}, {31'd0, i == 0 || i == 9});
      end
      tick();
      chk("b2b_idle", {31'd0, SERIAL_VALID}, 32'd0);
    end
    send_check(8'h3C, 8'hC3, fr);
    chk("stable_frame", {23'd0, fr}, {23'd0, 8'h3C, 1'b0});
    VALID_IN = 1'b1;
    DATA_IN  = 8'hF0;
    tick();
    VALID_IN = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_mid_bit3", {30'd0, SERIAL_VALID, SERIAL_OUT}, 32'd3);
    RESET = 1'b1;
    #1;
    chk("rst_mid_ready", {31'd0, READY_OUT}, 32'd0);
    tick();
    chk("rst_mid_line", {29'd0, SERIAL_VALID, SERIAL_OUT, FRAME_START}, 32'd0);
    RESET = 1'b0;
    #1;
    chk("rst_rel_ready", {31'd0, READY_OUT}, 32'd1);
    tick();
    chk("rst_rel_idle", {31'd0, SERIAL_VALID}, 32'd0);
    send_check(8'h0F, 8'hAA, fr);
    chk("after_rst_frame", {23'd0, fr}, {23'd0, 8'h0F, 1'b0});
    for (int v = 0; v < 256; v++) begin
      send_check(8'(v), 8'(~v), fr);
      chk("sweep_even", $countones(fr) % 2, 32'd0);
      chk("sweep_data", {24'd0, fr[8:1]}, v);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
